// File: rtl/neuraedge_energy_monitor_if.sv
// neuraedge_energy_monitor_if: control, power and energy-result bundle of the tile energy monitor
interface neuraedge_energy_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int PWR_W  = 16,
  parameter int ACC_W  = 64,
  parameter int WIN_W  = 16
);
  logic                    start_i;
  logic                    stop_i;
  logic                    clear_i;
  logic [NUM_CH-1:0]       ch_en_i;
  logic [NUM_CH*PWR_W-1:0] pwr_mw_i;
  logic [WIN_W-1:0]        win_len_i;
  logic [ACC_W-1:0]        budget_pj_i;
  logic [NUM_CH*ACC_W-1:0] ch_energy_pj_o;
  logic [ACC_W-1:0]        total_energy_pj_o;
  logic [ACC_W-1:0]        win_energy_pj_o;
  logic                    win_valid_o;
  logic                    sat_o;
  logic                    over_budget_o;
  logic                    running_o;
  modport master (
    output start_i, stop_i, clear_i, ch_en_i, pwr_mw_i, win_len_i, budget_pj_i,
    input  ch_energy_pj_o, total_energy_pj_o, win_energy_pj_o, win_valid_o, sat_o, over_budget_o, running_o
  );
  modport slave (
    input  start_i, stop_i, clear_i, ch_en_i, pwr_mw_i, win_len_i, budget_pj_i,
    output ch_energy_pj_o, total_energy_pj_o, win_energy_pj_o, win_valid_o, sat_o, over_budget_o, running_o
  );
endinterface

// File: rtl/neuraedge_energy_monitor.sv
// neuraedge_energy_monitor: per-channel mW x cycle-time -> pJ accumulator with exact fJ carry, saturation and windows.
// Optional budget comparator enabled by defining NEURAEDGE_EMON_BUDGET_EN.
module neuraedge_energy_monitor #(
  parameter int NUM_CH   = 4,
  parameter int PWR_W    = 16,
  parameter int CYCLE_PS = 2000,
  parameter int ACC_W    = 64,
  parameter int WIN_W    = 16
) (
  input logic                      clk,
  input logic                      reset,
  neuraedge_energy_monitor_if.slave bus
);
  localparam int PROD_W = PWR_W + $clog2(CYCLE_PS + 1);
  localparam int SUM_W  = PROD_W + 1;
  localparam int TOT_W  = SUM_W + $clog2(NUM_CH + 1);
  localparam int W      = (ACC_W > TOT_W ? ACC_W : TOT_W) + 1;
  localparam int CW     = WIN_W + 1;
  localparam logic [ACC_W-1:0] MAX = '1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic              s1_vld_q, s1_vld_d;
  logic [PROD_W-1:0] prod_q [NUM_CH], prod_d [NUM_CH];
  logic [9:0]        rem_q [NUM_CH], rem_d [NUM_CH];
  logic [ACC_W-1:0]  ch_q [NUM_CH], ch_d [NUM_CH];
  logic [ACC_W-1:0]  tot_q, tot_d, wsum_q, wsum_d, wen_q, wen_d;
  logic [WIN_W-1:0]  cnt_q, cnt_d;
  logic              wv_q, wv_d, sat_q, sat_d, ob_q, ob_d;
  logic [SUM_W-1:0]  sum [NUM_CH];
  logic [W-1:0]      ch_add [NUM_CH];
  logic [W-1:0]      tot_add, win_add;
  logic [TOT_W-1:0]  inc_tot;
  logic [CW-1:0]     cnt_nx;
  logic              close, ovf;
  function automatic logic [ACC_W-1:0] clip(input logic [W-1:0] v);
    return v > W'(MAX) ? MAX : v[ACC_W-1:0];
  endfunction
`ifndef NEURAEDGE_EMON_BUDGET_EN
  logic unused_budget;
  assign unused_budget = ^bus.budget_pj_i;
`endif
  always_comb begin
    state_d = (state_q == IDLE) ? ((bus.start_i && !bus.stop_i) ? RUN : IDLE) : (bus.stop_i ? IDLE : RUN);
    s1_vld_d = state_q == RUN;
    inc_tot = '0;
    ovf = 1'b0;
    // sum keeps the sub-pJ remainder so no energy is ever dropped between cycles
    for (int i = 0; i < NUM_CH; i++) begin
      prod_d[i] = (state_q == RUN && bus.ch_en_i[i]) ? PROD_W'(bus.pwr_mw_i[i*PWR_W +: PWR_W]) * PROD_W'(CYCLE_PS) : '0;
      sum[i] = SUM_W'(rem_q[i]) + SUM_W'(prod_q[i]);
      rem_d[i] = s1_vld_q ? 10'(sum[i] % SUM_W'(1000)) : rem_q[i];
      ch_add[i] = W'(ch_q[i]) + W'(sum[i] / SUM_W'(1000));
      ch_d[i] = s1_vld_q ? clip(ch_add[i]) : ch_q[i];
      ovf = ovf | (s1_vld_q && ch_add[i] > W'(MAX));
      inc_tot = inc_tot + (s1_vld_q ? TOT_W'(sum[i] / SUM_W'(1000)) : '0);
    end
    tot_add = W'(tot_q) + W'(inc_tot);
    win_add = W'(wsum_q) + W'(inc_tot);
    cnt_nx = CW'(cnt_q) + CW'(s1_vld_q);
    close = bus.win_len_i != '0 && cnt_nx >= CW'(bus.win_len_i);
    tot_d = clip(tot_add);
    wsum_d = (close || bus.win_len_i == '0) ? '0 : clip(win_add);
    cnt_d = (close || bus.win_len_i == '0) ? '0 : cnt_nx[WIN_W-1:0];
    wen_d = close ? clip(win_add) : wen_q;
    wv_d = close;
    sat_d = sat_q | ovf | (tot_add > W'(MAX)) | (win_add > W'(MAX));
`ifdef NEURAEDGE_EMON_BUDGET_EN
    ob_d = ob_q | (tot_q > bus.budget_pj_i);
`else
    ob_d = 1'b0;
`endif
    if (bus.clear_i) begin
      s1_vld_d = 1'b0;
      tot_d = '0;
      wsum_d = '0;
      wen_d = '0;
      cnt_d = '0;
      wv_d = 1'b0;
      sat_d = 1'b0;
      ob_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rem_d[i] = '0;
        ch_d[i] = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s1_vld_q <= 1'b0;
      prod_q <= '{default: '0};
      rem_q <= '{default: '0};
      ch_q <= '{default: '0};
      tot_q <= '0;
      wsum_q <= '0;
      wen_q <= '0;
      cnt_q <= '0;
      wv_q <= 1'b0;
      sat_q <= 1'b0;
      ob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_vld_q <= s1_vld_d;
      prod_q <= prod_d;
      rem_q <= rem_d;
      ch_q <= ch_d;
      tot_q <= tot_d;
      wsum_q <= wsum_d;
      wen_q <= wen_d;
      cnt_q <= cnt_d;
      wv_q <= wv_d;
      sat_q <= sat_d;
      ob_q <= ob_d;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign bus.ch_energy_pj_o[c*ACC_W +: ACC_W] = ch_q[c];
  end
  assign bus.total_energy_pj_o = tot_q;
  assign bus.win_energy_pj_o = wen_q;
  assign bus.win_valid_o = wv_q;
  assign bus.sat_o = sat_q;
  assign bus.over_budget_o = ob_q;
  assign bus.running_o = state_q == RUN;
endmodule

// File: tb/tb_neuraedge_energy_monitor.sv
// tb_neuraedge_energy_monitor: table + scoreboard bench; instance a is the default build, b is a 333 ps / 16-bit variant.
module tb_neuraedge_energy_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  neuraedge_energy_monitor_if #(.NUM_CH(4), .PWR_W(16), .ACC_W(64), .WIN_W(16)) ia ();
  neuraedge_energy_monitor_if #(.NUM_CH(2), .PWR_W(16), .ACC_W(16), .WIN_W(16)) ib ();
  neuraedge_energy_monitor #(.NUM_CH(4), .PWR_W(16), .CYCLE_PS(2000), .ACC_W(64), .WIN_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(ia));
  neuraedge_energy_monitor #(.NUM_CH(2), .PWR_W(16), .CYCLE_PS(333), .ACC_W(16), .WIN_W(16)) u_b (
    .clk(clk), .reset(reset), .bus(ib));
  typedef struct {
    logic [3:0]  en;
    logic [63:0] pwr;
    int          n;
    logic [63:0] e0, e1, e2, e3, et;
  } vec_t;
  vec_t tv [5];
  vec_t sb [$];
  vec_t ex;
  int total = 0, bad = 0, pulses = 0, p = 0;
  logic [63:0] last_win = '0;
  always begin
    @(posedge clk);
    #1;
    if (ia.win_valid_o) begin
      pulses++;
      last_win = ia.win_energy_pj_o;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic ctl(input logic s, input logic t, input logic c);
    ia.start_i = s; ia.stop_i = t; ia.clear_i = c;
    ib.start_i = s; ib.stop_i = t; ib.clear_i = c;
  endtask
  task automatic clr();
    ctl(0, 0, 1);
    tick();
    ctl(0, 0, 0);
  endtask
  // start, n captured products in total, stop on the last capture, then drain
  task automatic run(input int n);
    ctl(1, 0, 0);
    tick();
    ctl(0, 0, 0);
    chk("running", 64'(ia.running_o), 64'd1);
    repeat (n - 1) tick();
    ctl(0, 1, 0);
    tick();
    ctl(0, 0, 0);
    tick();
    tick();
    chk("stopped", 64'(ia.running_o), 64'd0);
  endtask
  initial begin
    tv[0] = '{4'b0011, {16'd9, 16'd7, 16'd100, 16'd50}, 40, 64'd4000, 64'd8000, 64'd0, 64'd0, 64'd12000};
    tv[1] = '{4'b0011, {16'd9, 16'd7, 16'd100, 16'd50}, 80, 64'd12000, 64'd24000, 64'd0, 64'd0, 64'd36000};
    tv[2] = '{4'b0100, {16'd9, 16'd7, 16'd100, 16'd50}, 10, 64'd12000, 64'd24000, 64'd140, 64'd0, 64'd36140};
    tv[3] = '{4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 5, 64'd12010, 64'd24020, 64'd170, 64'd40, 64'd36240};
    tv[4] = '{4'b1001, {16'd1000, 16'd0, 16'd0, 16'd65535}, 3, 64'd405220, 64'd24020, 64'd170, 64'd6040, 64'd435450};
    ctl(0, 0, 0);
    ia.ch_en_i = '0; ia.pwr_mw_i = '0; ia.win_len_i = '0; ia.budget_pj_i = 64'd5000;
    ib.ch_en_i = '0; ib.pwr_mw_i = '0; ib.win_len_i = '0; ib.budget_pj_i = 16'd100;
    @(negedge clk);
    @(negedge clk);
    chk("rst total", ia.total_energy_pj_o, 64'd0);
    chk("rst ch0", ia.ch_energy_pj_o[63:0], 64'd0);
    chk("rst running", 64'(ia.running_o), 64'd0);
    chk("rst win_valid", 64'(ia.win_valid_o), 64'd0);
    chk("rst sat", 64'(ia.sat_o), 64'd0);
    chk("rst win_energy", ia.win_energy_pj_o, 64'd0);
    reset = 1'b0;
    tick();
    ctl(1, 1, 0);
    tick();
    ctl(0, 0, 0);
    chk("start&stop idle", 64'(ia.running_o), 64'd0);
    ia.ch_en_i = 4'b1111; ia.pwr_mw_i = {4{16'd100}};
    tick();
    tick();
    chk("idle no accumulation", ia.total_energy_pj_o, 64'd0);
    for (int k = 0; k < 5; k++) begin
      ia.ch_en_i = tv[k].en;
      ia.pwr_mw_i = tv[k].pwr;
      sb.push_back(tv[k]);
      run(tv[k].n);
      ex = sb.pop_front();
      chk($sformatf("v%0d ch0", k), ia.ch_energy_pj_o[63:0], ex.e0);
      chk($sformatf("v%0d ch1", k), ia.ch_energy_pj_o[127:64], ex.e1);
      chk($sformatf("v%0d ch2", k), ia.ch_energy_pj_o[191:128], ex.e2);
      chk($sformatf("v%0d ch3", k), ia.ch_energy_pj_o[255:192], ex.e3);
      chk($sformatf("v%0d total", k), ia.total_energy_pj_o, ex.et);
    end
    chk("no sat", 64'(ia.sat_o), 64'd0);
    chk("win off pulses", 64'(pulses), 64'd0);
    clr();
    chk("clear total", ia.total_energy_pj_o, 64'd0);
    chk("clear ch0", ia.ch_energy_pj_o[63:0], 64'd0);
    chk("clear ch3", ia.ch_energy_pj_o[255:192], 64'd0);
    ia.ch_en_i = 4'b0001; ia.pwr_mw_i = {48'd0, 16'd100};
    ctl(1, 0, 0);
    tick();
    ctl(0, 0, 0);
    repeat (4) tick();
    chk("pre-clear total", ia.total_energy_pj_o, 64'd600);
    ctl(0, 0, 1);
    tick();
    ctl(0, 0, 0);
    chk("clear in run", ia.total_energy_pj_o, 64'd0);
    chk("clear keeps state", 64'(ia.running_o), 64'd1);
    ctl(0, 1, 0);
    tick();
    ctl(0, 0, 0);
    tick();
    tick();
    chk("one after clear", ia.total_energy_pj_o, 64'd200);
    chk("stop in-flight ch0", ia.ch_energy_pj_o[63:0], 64'd200);
    clr();
    ia.win_len_i = 16'd50;
    p = pulses;
    run(150);
    chk("win pulses", 64'(pulses - p), 64'd3);
    chk("win last", last_win, 64'd10000);
    chk("win energy", ia.win_energy_pj_o, 64'd10000);
    ia.win_len_i = 16'd0;
    p = pulses;
    run(120);
    chk("win0 pulses", 64'(pulses - p), 64'd0);
    chk("win0 hold", ia.win_energy_pj_o, 64'd10000);
    chk("win total", ia.total_energy_pj_o, 64'd54000);
    clr();
    ia.win_len_i = 16'd100;
    run(30);
    p = pulses;
    ia.win_len_i = 16'd20;
    tick();
    tick();
    chk("shrink pulses", 64'(pulses - p), 64'd1);
    chk("shrink energy", ia.win_energy_pj_o, 64'd6000);
    ctl(1, 0, 0);
    tick();
    ctl(0, 0, 0);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst total", ia.total_energy_pj_o, 64'd0);
    chk("arst ch0", ia.ch_energy_pj_o[63:0], 64'd0);
    chk("arst running", 64'(ia.running_o), 64'd0);
    chk("arst win", ia.win_energy_pj_o, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    chk("post-arst total", ia.total_energy_pj_o, 64'd0);
    ia.ch_en_i = '0; ia.win_len_i = '0;
    ib.ch_en_i = 2'b01; ib.pwr_mw_i = {16'd500, 16'd3};
    run(1);
    chk("frac 1", 64'(ib.ch_energy_pj_o[15:0]), 64'd0);
    run(999);
    chk("frac 1000", 64'(ib.ch_energy_pj_o[15:0]), 64'd999);
    chk("frac total", 64'(ib.total_energy_pj_o), 64'd999);
    run(2);
    chk("frac 1002", 64'(ib.ch_energy_pj_o[15:0]), 64'd1000);
    chk("frac ch1 off", 64'(ib.ch_energy_pj_o[31:16]), 64'd0);
    clr();
    ib.pwr_mw_i = {16'd500, 16'd60000};
    run(3);
    chk("sat pre", 64'(ib.ch_energy_pj_o[15:0]), 64'd59940);
    chk("sat pre flag", 64'(ib.sat_o), 64'd0);
    run(1);
    chk("sat ch0", 64'(ib.ch_energy_pj_o[15:0]), 64'd65535);
    chk("sat total", 64'(ib.total_energy_pj_o), 64'd65535);
    chk("sat flag", 64'(ib.sat_o), 64'd1);
    run(2);
    chk("sat hold", 64'(ib.ch_energy_pj_o[15:0]), 64'd65535);
    chk("sat sticky", 64'(ib.sat_o), 64'd1);
    clr();
    chk("sat clear ch0", 64'(ib.ch_energy_pj_o[15:0]), 64'd0);
    chk("sat clear flag", 64'(ib.sat_o), 64'd0);
    chk("budget off a", 64'(ia.over_budget_o), 64'd0);
    chk("budget off b", 64'(ib.over_budget_o), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
